vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 15 +
 rtl/vga_timing_gen_sync_delay_line.sv | 34 +++
 rtl/vga_timing_gen.sv | 77 +++++++
 tb/tb_vga_timing_gen.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Default 640x480@60 VGA timing constants and the coordinate type.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_VISIBLE  = 640;
  localparam int H_FRONT    = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BACK     = 48;
  localparam int V_VISIBLE  = 480;
  localparam int V_FRONT    = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BACK     = 33;
  localparam int SYNC_DELAY = 2;

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;  // 800
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;  // 525

  // Sync pulse windows, half-open [START, END).
  localparam coord_t HS_START = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_END   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_START = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_END   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster coordinate / sync bundle from the timing generator to image modules.
interface vga_timing_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   blank;
  logic   hs;
  logic   vs;
  logic   line_start;
  logic   frame_start;

  modport master (output DrawX, DrawY, blank, hs, vs, line_start, frame_start);
  modport slave  (input  DrawX, DrawY, blank, hs, vs, line_start, frame_start);
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth shift register with all-ones reset; DEPTH=0 is a plain wire.
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;
    end else begin : g_pipe
      // tap[k] is the value after k register stages.
      wire [WIDTH-1:0] tap [DEPTH+1];
      assign tap[0] = din;

      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        logic [WIDTH-1:0] q_reg;
        // One delay stage; idles high so sync outputs are inactive after reset.
        always_ff @(posedge clk) begin
          if (rst) q_reg <= '1;
          else     q_reg <= tap[gi];
        end
        assign tap[gi+1] = q_reg;
      end

      assign dout = tap[DEPTH];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster counters, active-video / start decodes and pipelined sync outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int H_FRONT    = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BACK     = vga_timing_pkg::H_BACK,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int V_FRONT    = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BACK     = vga_timing_pkg::V_BACK,
  parameter int SYNC_DELAY = vga_timing_pkg::SYNC_DELAY
) (
  input  logic            vga_clk,
  input  logic            reset,
  vga_timing_if.master    vga
);

  localparam coord_t H_MAX   = coord_t'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam coord_t V_MAX   = coord_t'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam coord_t H_VIS_C = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);
  localparam coord_t HS_ON   = coord_t'(H_VISIBLE + H_FRONT);
  localparam coord_t HS_OFF  = coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam coord_t VS_ON   = coord_t'(V_VISIBLE + V_FRONT);
  localparam coord_t VS_OFF  = coord_t'(V_VISIBLE + V_FRONT + V_SYNC);

  coord_t     h_cnt_reg;
  coord_t     v_cnt_reg;
  logic       hs_raw;
  logic       vs_raw;
  logic [1:0] sync_out;

  // Pixel/line counters; the line counter only moves on the end-of-line wrap.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_MAX) begin
      h_cnt_reg <= '0;
      if (v_cnt_reg == V_MAX) v_cnt_reg <= '0;
      else                    v_cnt_reg <= v_cnt_reg + 10'd1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 10'd1;
    end
  end

  // Undelayed active-low syncs decoded straight from the counters.
  always_comb begin
    hs_raw = !((h_cnt_reg >= HS_ON) && (h_cnt_reg < HS_OFF));
    vs_raw = !((v_cnt_reg >= VS_ON) && (v_cnt_reg < VS_OFF));
  end

  // Syncs are delayed to match the ROM read + palette register latency.
  sync_delay_line #(
    .WIDTH (2),
    .DEPTH (SYNC_DELAY)
  ) u_sync_delay (
    .clk  (vga_clk),
    .rst  (reset),
    .din  ({hs_raw, vs_raw}),
    .dout (sync_out)
  );

  // Coordinates and decodes are aligned with the counter registers.
  always_comb begin
    vga.DrawX       = h_cnt_reg;
    vga.DrawY       = v_cnt_reg;
    vga.blank       = (h_cnt_reg < H_VIS_C) && (v_cnt_reg < V_VIS_C);
    vga.line_start  = (h_cnt_reg == '0);
    vga.frame_start = (h_cnt_reg == '0) && (v_cnt_reg == '0);
    vga.hs          = sync_out[1];
    vga.vs          = sync_out[0];
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default timing (delay 2 and 0) plus a tiny raster.
module tb_vga_timing_gen;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #20 clk = ~clk;

  vga_timing_if if_a ();
  vga_timing_if if_b ();
  vga_timing_if if_c ();

  // Default 640x480 timing, sync delay 2.
  vga_timing_gen dut_a (.vga_clk(clk), .reset(reset), .vga(if_a));

  // Tiny raster: 16 clocks/line, 11 lines/frame, 176 clocks/frame.
  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(2)
  ) dut_b (.vga_clk(clk), .reset(reset), .vga(if_b));

  // Default timing, syncs undelayed.
  vga_timing_gen #(.SYNC_DELAY(0)) dut_c (.vga_clk(clk), .reset(reset), .vga(if_c));

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
  } obs_t;

  int checks   = 0;
  int failures = 0;
  int printed  = 0;
  int t_cnt    = 0;
  bit valid    = 1'b0;
  int last_fs  = 0;

  // Clocks elapsed since the last reset edge.
  always @(posedge clk) begin
    if (reset) begin
      t_cnt <= 0;
      valid <= 1'b1;
    end else if (valid) begin
      t_cnt <= t_cnt + 1;
    end
  end

  // Reference raster: position is elapsed time modulo line/frame length.
  function automatic obs_t model(int t, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw, int vb, int d);
    obs_t o;
    int ht = hv + hf + hsw + hb;
    int vt = vv + vf + vsw + vb;
    int xi = t % ht;
    int yi = (t / ht) % vt;
    o.x     = 10'(xi);
    o.y     = 10'(yi);
    o.blank = (xi < hv) && (yi < vv);
    o.ls    = (xi == 0);
    o.fs    = (xi == 0) && (yi == 0);
    if (t < d) begin
      o.hs = 1'b1;
      o.vs = 1'b1;
    end else begin
      int xs = (t - d) % ht;
      int ys = ((t - d) / ht) % vt;
      o.hs = !((xs >= hv + hf) && (xs < hv + hf + hsw));
      o.vs = !((ys >= vv + vf) && (ys < vv + vf + vsw));
    end
    return o;
  endfunction

  task automatic cmp(string nm, obs_t e, obs_t a);
    checks++;
    if (a !== e) begin
      failures++;
      if (printed < 20) begin
        printed++;
        $display("FAIL %s t=%0d actual x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b required x=%0d y=%0d bl=%b hs=%b vs=%b ls=%b fs=%b",
                 nm, t_cnt, a.x, a.y, a.blank, a.hs, a.vs, a.ls, a.fs,
                 e.x, e.y, e.blank, e.hs, e.vs, e.ls, e.fs);
      end
    end
  endtask

  task automatic lit(string nm, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", nm, t_cnt, act, req);
    end
  endtask

  // Per-cycle comparison of every instance against the reference raster.
  always @(negedge clk) begin
    if (valid) begin
      cmp("dut_a", model(t_cnt, 640, 16, 96, 48, 480, 10, 2, 33, 2),
          {if_a.DrawX, if_a.DrawY, if_a.blank, if_a.hs, if_a.vs, if_a.line_start, if_a.frame_start});
      cmp("dut_b", model(t_cnt, 8, 2, 3, 3, 6, 1, 2, 2, 2),
          {if_b.DrawX, if_b.DrawY, if_b.blank, if_b.hs, if_b.vs, if_b.line_start, if_b.frame_start});
      cmp("dut_c", model(t_cnt, 640, 16, 96, 48, 480, 10, 2, 33, 0),
          {if_c.DrawX, if_c.DrawY, if_c.blank, if_c.hs, if_c.vs, if_c.line_start, if_c.frame_start});
      checks++;
      if (int'(if_a.DrawX) > 799 || int'(if_a.DrawY) > 524 ||
          int'(if_b.DrawX) > 15 || int'(if_b.DrawY) > 10) begin
        failures++;
        $display("FAIL range t=%0d actual a=(%0d,%0d) b=(%0d,%0d) required a<=(799,524) b<=(15,10)",
                 t_cnt, if_a.DrawX, if_a.DrawY, if_b.DrawX, if_b.DrawY);
      end
      if (if_b.frame_start) begin
        if (t_cnt != 0) lit("b_frame_period", t_cnt - last_fs, 176);
        last_fs = t_cnt;
      end
    end
  end

  task automatic goto(int n);
    int guard = 0;
    while (t_cnt != n) begin
      @(negedge clk);
      guard++;
      if (guard > 20000) begin
        failures++;
        $display("FAIL goto_timeout actual=%0d required=%0d", t_cnt, n);
        return;
      end
    end
  endtask

  // Called at the negedge right after a reset edge; releases reset and walks a line.
  task automatic cold_checks(string tag);
    $display("phase %s: post-reset values", tag);
    lit("rst_x", int'(if_a.DrawX), 0);
    lit("rst_y", int'(if_a.DrawY), 0);
    lit("rst_blank", int'(if_a.blank), 1);
    lit("rst_ls", int'(if_a.line_start), 1);
    lit("rst_fs", int'(if_a.frame_start), 1);
    lit("rst_hs", int'(if_a.hs), 1);
    lit("rst_vs", int'(if_a.vs), 1);
    lit("rst_b_hs", int'(if_b.hs), 1);
    lit("rst_b_vs", int'(if_b.vs), 1);
    reset = 1'b0;
    goto(1);   lit("x_after_1", int'(if_a.DrawX), 1); lit("fs_after_1", int'(if_a.frame_start), 0);
    $display("phase %s: tiny raster frame", tag);
    goto(96);  lit("b_blank_line6", int'(if_b.blank), 0);
    goto(113); lit("b_vs_before", int'(if_b.vs), 1);
    goto(114); lit("b_vs_fall", int'(if_b.vs), 0);
    goto(145); lit("b_vs_last", int'(if_b.vs), 0);
    goto(146); lit("b_vs_rise", int'(if_b.vs), 1);
    goto(175); lit("b_x_end", int'(if_b.DrawX), 15); lit("b_y_end", int'(if_b.DrawY), 10);
    goto(176); lit("b_x_wrap", int'(if_b.DrawX), 0); lit("b_y_wrap", int'(if_b.DrawY), 0);
    lit("b_fs_wrap", int'(if_b.frame_start), 1);
    $display("phase %s: default line", tag);
    goto(639); lit("blank_639", int'(if_a.blank), 1);
    goto(640); lit("blank_640", int'(if_a.blank), 0);
    goto(655); lit("c_hs_655", int'(if_c.hs), 1);
    goto(656); lit("c_hs_656", int'(if_c.hs), 0);
    goto(657); lit("hs_657", int'(if_a.hs), 1);
    goto(658); lit("hs_658", int'(if_a.hs), 0);
    goto(751); lit("c_hs_751", int'(if_c.hs), 0);
    goto(752); lit("c_hs_752", int'(if_c.hs), 1);
    goto(753); lit("hs_753", int'(if_a.hs), 0);
    goto(754); lit("hs_754", int'(if_a.hs), 1);
    goto(799); lit("x_799", int'(if_a.DrawX), 799);
    goto(800); lit("x_wrap", int'(if_a.DrawX), 0); lit("y_inc", int'(if_a.DrawY), 1);
    lit("ls_wrap", int'(if_a.line_start), 1);
  endtask

  initial begin
    #(40 * 50000);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    cold_checks("cold");

    // Mid-frame reset: dut_a at (300,2), dut_b inside its vsync pulse.
    goto(1900);
    $display("phase mid: reset at a=(%0d,%0d)", if_a.DrawX, if_a.DrawY);
    lit("pre_a_x", int'(if_a.DrawX), 300);
    lit("pre_b_vs", int'(if_b.vs), 0);
    lit("pre_b_hs", int'(if_b.hs), 0);
    reset = 1'b1;
    @(negedge clk);
    cold_checks("warm");

    goto(4000);
    $display("phase run: %0d tiny frames checked", 4000 / 176);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
